// File: rtl/bitwise_operations.sv
// Registered bitwise logic unit: AND / OR / XOR / NOT-a of two WIDTH-bit
// operands, presented on q one clock after the operands are sampled.
module bitwise_operations #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // NOT ignores b entirely; every case is purely per-bit, no carries.
    always_comb begin
        q_d = '0;
        case (op_e'(op))
            OP_AND:  q_d = a & b;
            OP_OR:   q_d = a | b;
            OP_XOR:  q_d = a ^ b;
            OP_NOT:  q_d = ~a;
            default: q_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_bitwise_operations.sv
// Randomized and directed bench for bitwise_operations: a driver queues the
// expected result per issued operation, a monitor pops and compares each edge.
module tb_bitwise_operations;

    localparam int W = 7;

    logic         clk;
    logic         rst;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [1:0]   op_i;
    logic [W-1:0] q_o;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_exp;
    int           n_cmp;
    int           n_bad;

    bitwise_operations #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .a  (a_i),
        .b  (b_i),
        .op (op_i),
        .q  (q_o)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Per-bit truth table indexed by {op, a_bit, b_bit}.
    function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0] op);
        logic [15:0] tt;
        logic [W-1:0] r;
        // op=11 row: 1,1,0,0 for ab=00,01,10,11
        // op=10 row: 0,1,1,0 ; op=01 row: 0,1,1,1 ; op=00 row: 0,0,0,1
        tt = 16'b0011_0110_1110_1000;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[i] = tt[{op, a[i], b[i]}];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply operands at the falling edge; q must still show the previous
    // result (no combinational path), then queue the result due next edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
        logic [W-1:0] e;
        @(negedge clk);
        a_i  = a;
        b_i  = b;
        op_i = op;
        #1;
        check("hold", q_o, prev_exp);
        e = model(a, b, op);
        exp_q.push_back(e);
        prev_exp = e;
    endtask

    task automatic drain();
        int budget;
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", q_o, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        prev_exp = '0;
        a_i      = 7'b1111111;
        b_i      = 7'b1111111;
        op_i     = 2'b01;
        rst      = 1'b0;

        // 1. Reset: q clears immediately and stays 0 across edges.
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", q_o, 7'b0000000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", q_o, 7'b0000000);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model(a_i, b_i, op_i));
        prev_exp = 7'b1111111;
        @(posedge clk);
        #2;
        check("reset_release", q_o, 7'b1111111);

        // 2/3. Directed AND/OR/XOR/NOT.
        drive(7'b1010101, 7'b1100110, 2'b00);
        drive(7'b1010101, 7'b1100110, 2'b01);
        drive(7'b1010101, 7'b1100110, 2'b10);
        drive(7'b1010101, 7'b1100110, 2'b11);
        drive(7'b1010101, 7'b0000000, 2'b11);
        drain();
        check("not_ignores_b", q_o, 7'b0101010);

        // 4. op cycling with random operands.
        for (int i = 0; i < 20; i++) begin
            drive(W'($urandom_range(0, 127)), W'($urandom_range(0, 127)), 2'(i % 4));
        end
        drain();

        // Extra random traffic with random op.
        for (int i = 0; i < 40; i++) begin
            drive(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
        end
        drain();

        // 6. Boundary operands.
        for (int o = 0; o < 4; o++) drive('0, '0, 2'(o));
        drain();
        check("zero_not", q_o, 7'b1111111);
        for (int o = 0; o < 4; o++) drive('1, '1, 2'(o));
        drain();
        check("ones_not", q_o, 7'b0000000);

        // 5. Async reset mid-operation discards the pending result.
        drive(7'b1111111, 7'b1111111, 2'b01);
        drive(7'b1111111, 7'b0000000, 2'b01);
        drain();
        check("pre_reset", q_o, 7'b1111111);
        drive(7'b0000000, 7'b0000000, 2'b01);
        #2;
        rst = 1'b1;
        exp_q.delete();
        prev_exp = '0;
        #1;
        check("mid_reset_async", q_o, 7'b0000000);
        @(posedge clk);
        #1;
        check("mid_reset_hold", q_o, 7'b0000000);
        @(negedge clk);
        a_i  = 7'b0000001;
        b_i  = 7'b0000011;
        op_i = 2'b10;
        rst  = 1'b0;
        exp_q.push_back(model(a_i, b_i, op_i));
        prev_exp = model(a_i, b_i, op_i);
        drain();
        check("post_reset_xor", q_o, 7'b0000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitwise_operations.md
Name: bitwise_operations

Overview:
Registered bitwise logic unit. Each clock it applies one of four bitwise operations, chosen by op, to two WIDTH-bit operands. The result is presented on q one cycle later. It is a small datapath leaf used as an exerciser/ALU slice: a and b come from upstream registers, and q feeds downstream logic or a logger.

Parameters:
WIDTH, 7, operand and result width in bits (minimum 1).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high; clears q.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
op  input  2  operation select.
q  output  WIDTH  registered result.

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, q=0 immediately, without waiting for a clock edge, and q holds 0.
  - On the first rising clk edge after rst is deasserted, normal operation resumes. No extra idle cycle.
- Operation encoding, combinational result r:
  - op=2'b00: r = a AND b
  - op=2'b01: r = a OR b
  - op=2'b10: r = a XOR b
  - op=2'b11: r = NOT a (bitwise complement of a; b ignored)
- Registering:
  - On each rising clk edge with rst=0: q <= r, computed from the a, b and op values sampled at that edge.
  - Latency is exactly 1 cycle. Throughput is one result per cycle. There is no handshake, enable or valid signal.
  - q changes only on a rising clk edge or on assertion of rst. It does not change combinationally with a, b or op.
- Width rules:
  - Operations are strictly bitwise. Bit i of q depends only on bit i of a and bit i of b.
  - No carries, no sign handling, no truncation or extension.
- op changing every cycle: each edge uses the op value present at that edge. There is no history dependence.
- Reset asserted mid-stream: q goes to 0 asynchronously and the pending result is discarded.
- Reset released coincident with a clock edge: the result of that edge is don't-care. Benches sample q one cycle after rst deassertion plus one edge.
- X/Z on inputs propagate bitwise per standard logic rules. No special handling.
- Simulation start without reset: q is unknown until the first clock edge. Reset is still required by the system.

Test Plan:
1. Reset: assert rst with a=7'b1111111, b=7'b1111111, op=2'b01, then toggle clk -> q=7'b0000000 immediately and on every edge while rst=1. After release, the next edge gives q=7'b1111111.
2. AND/OR: a=7'b1010101, b=7'b1100110.
   - op=00 -> q=7'b1000100 after 1 edge.
   - op=01 -> q=7'b1110111 after 1 edge.
3. XOR/NOT: a=7'b1010101, b=7'b1100110.
   - op=10 -> q=7'b0110011.
   - op=11 -> q=7'b0101010, independent of b; repeat with b=7'b0000000 and get the same q.
4. op cycling: op sequence 00,01,10,11,00 on consecutive edges, with random a/b each cycle (20 cycles) -> each q equals the reference model of the a, b and op applied one edge earlier. Check latency is 1 cycle exactly.
5. Async reset mid-operation: with q=7'b1111111 steady, assert rst between clock edges -> q=0 before the next edge. Deassert rst with a=7'b0000001, b=7'b0000011, op=10 -> q=7'b0000010 after the next edge.
6. Boundary operands: a=0, b=0 -> op=00,01,10 give 0 and op=11 gives 7'b1111111. a=b=7'b1111111 -> AND=OR=7'b1111111, XOR=0, NOT=0.
